mux_scan_ctrl: RTL

Sequencer that drives the select lines of the 4:1 mux (`mux_4_`) and consumes its output. On command it steps the select through all four channels, holds each for a programmable dwell time so the mux output settles, samples the mux output once per channel, and publishes the four samples as one 4-bit word with a one-cycle valid strobe. It sits around the mux: the `s1`/`s2` outputs feed the mux select inputs, and the mux `out` returns on `mux_out`.

---
 rtl/mux_scan_ctrl_pkg.sv | 16 +
 rtl/mux_scan_if.sv | 24 ++
 rtl/mux_scan_ctrl_dwell_counter.sv | 27 ++
 rtl/mux_scan_ctrl.sv | 104 ++++++++++
 4 files changed

// File: rtl/mux_scan_ctrl_pkg.sv
// Shared types for the mux scan sequencer.
// State encoding and channel-to-word-bit mapping.
package mux_scan_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_SCAN = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   localparam logic [1:0] CH_A = 2'd0;
   localparam logic [1:0] CH_B = 2'd1;
   localparam logic [1:0] CH_C = 2'd2;
   localparam logic [1:0] CH_D = 2'd3;

endpackage

// File: rtl/mux_scan_if.sv
// Bundle between the scan sequencer and its host/mux.
// The slave side is the sequencer itself.
interface mux_scan_if;

   logic       start;
   logic       cont;
   logic       mux_out;
   logic       s1;
   logic       s2;
   logic       busy;
   logic       valid;
   logic [3:0] word;

   modport master (
      output start, cont, mux_out,
      input  s1, s2, busy, valid, word
   );

   modport slave (
      input  start, cont, mux_out,
      output s1, s2, busy, valid, word
   );

endinterface

// File: rtl/mux_scan_ctrl_dwell_counter.sv
// Dwell counter: counts cycles a select value is held.
// last flags the final cycle of the dwell window.
module dwell_counter #(
   parameter int DWELL = 4,
   parameter int CW    = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic last
);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (en)
         cnt <= cnt + CW'(1);
   end

   assign last = (cnt == CW'(DWELL - 1));

endmodule

// File: rtl/mux_scan_ctrl.sv
// Steps the 4:1 mux select through all channels and
// publishes the four sampled bits as one word.
module mux_scan_ctrl
   import mux_scan_ctrl_pkg::*;
#(
   parameter int DWELL = 4,
   parameter int CW    = 3
) (
   input logic       clk,
   input logic       reset,
   mux_scan_if.slave bus
);

   state_t     state;
   state_t     state_nxt;
   logic [1:0] sel;
   logic [1:0] sel_nxt;
   logic [3:0] smp_q;
   logic [3:0] smp_nxt;
   logic [3:0] word_q;
   logic       valid_q;
   logic       last;
   logic       cnt_clr;
   logic       cnt_en;
   logic       fin;

   dwell_counter #(
      .DWELL (DWELL),
      .CW    (CW)
   ) u_dwell (
      .clk   (clk),
      .reset (reset),
      .clr   (cnt_clr),
      .en    (cnt_en),
      .last  (last)
   );

   always_ff @(posedge clk) begin
      if (reset)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      sel_nxt   = sel;
      smp_nxt   = smp_q;
      cnt_en    = 1'b0;
      cnt_clr   = 1'b1;
      fin       = 1'b0;
      case (state)
         ST_IDLE: begin
            sel_nxt = CH_A;
            if (bus.start)
               state_nxt = ST_SCAN;
         end
         ST_SCAN: begin
            cnt_en  = 1'b1;
            cnt_clr = last;
            if (last) begin
               smp_nxt[sel] = bus.mux_out;
               if (sel == CH_D) begin
                  state_nxt = ST_DONE;
                  fin       = 1'b1;
               end else begin
                  sel_nxt = sel + 2'd1;
               end
            end
         end
         ST_DONE: begin
            sel_nxt   = CH_A;
            state_nxt = bus.cont ? ST_SCAN : ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
            sel_nxt   = CH_A;
         end
      endcase
   end

   // word/valid load on the final sample edge so they show in DONE
   always_ff @(posedge clk) begin
      if (reset) begin
         sel     <= CH_A;
         smp_q   <= '0;
         word_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         sel     <= sel_nxt;
         smp_q   <= smp_nxt;
         valid_q <= fin;
         if (fin)
            word_q <= smp_nxt;
      end
   end

   assign bus.s1    = sel[1];
   assign bus.s2    = sel[0];
   assign bus.busy  = (state != ST_IDLE);
   assign bus.valid = valid_q;
   assign bus.word  = word_q;

endmodule
